// File: rtl/mem_copy_engine.sv
// mem_copy_engine
// ---------------
// A small DMA that copies len bytes from src to dst through the 8-bit
// data-memory port. The memory reads combinationally and writes on the
// clock edge, so each byte needs one read cycle and then one write cycle.
// While busy=1 the CPU arbiter gives the memory port to this block.
//
// Optional feature: define CHECKSUM_EN to add the csum output, which is the
// modulo-2**DATA_W sum of every byte written in the current or last transfer.
//
// Ports
//   clk        in   clock; all state changes on posedge
//   reset      in   synchronous, active-high reset
//   start      in   transfer request; accepted only in IDLE
//   src, dst   in   source and destination base addresses, sampled on accept
//   len        in   byte count, sampled on accept; 0 means no-op
//   busy       out  high in the RD and WR states
//   done       out  one-cycle completion pulse, asserted in the FIN state
//   err        out  an out-of-range access was attempted; held until next accept
//   count      out  bytes written so far
//   mem_addr   out  memory address
//   mem_wdata  out  memory write data
//   mem_read   out  memory read strobe
//   mem_write  out  memory write strobe; memory commits at the cycle's posedge
//   mem_rdata  in   memory read data, combinational from mem_addr
//   csum       out  running byte checksum (only with CHECKSUM_EN)
//   state_dbg  out  current FSM state: 0=IDLE 1=RD 2=WR 3=FIN
//
// Handshake: start is a level request. It is accepted on a rising edge where
// the FSM is in IDLE. At any other time it is ignored. There is no
// back-pressure on the memory side. A strobe that is high in a cycle is
// serviced in that same cycle.
module mem_copy_engine #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int MEM_DEPTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [7:0]        len,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [7:0]        count,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
`ifdef CHECKSUM_EN
   output logic [DATA_W-1:0] csum,
`endif
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      FIN  = 2'd3
   } state_t;

   // Extra bit so that MEM_DEPTH = 2**ADDR_W can be represented.
   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);
   localparam logic [ADDR_W-1:0] ONE_A   = 1;

   state_t            state;
   logic [ADDR_W-1:0] src_ptr;
   logic [ADDR_W-1:0] dst_ptr;
   logic [7:0]        remaining;

   function automatic logic in_range(input logic [ADDR_W-1:0] p);
      return {1'b0, p} < DEPTH_L;
   endfunction

   assign state_dbg = state;

   // All outputs are registered. The strobes and the address are therefore
   // computed on the edge that enters a state, from the pointer values that
   // state will use.
   // mem_wdata doubles as the byte buffer between the RD and WR cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         src_ptr   <= '0;
         dst_ptr   <= '0;
         remaining <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         count     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
`ifdef CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  src_ptr   <= src;
                  dst_ptr   <= dst;
                  remaining <= len;
                  count     <= '0;
                  err       <= 1'b0;
`ifdef CHECKSUM_EN
                  csum      <= '0;
`endif
                  if (len == 8'd0) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end else begin
                     state    <= RD;
                     busy     <= 1'b1;
                     mem_addr <= src;
                     mem_read <= in_range(src);
                  end
               end
            end

            RD: begin
               mem_read <= 1'b0;
               if (!in_range(src_ptr)) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= FIN;
               end else begin
                  mem_wdata <= mem_rdata;
                  mem_addr  <= dst_ptr;
                  mem_write <= in_range(dst_ptr);
                  state     <= WR;
               end
            end

            WR: begin
               mem_write <= 1'b0;
               if (!in_range(dst_ptr)) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= FIN;
               end else begin
                  src_ptr   <= src_ptr + ONE_A;
                  dst_ptr   <= dst_ptr + ONE_A;
                  count     <= count + 8'd1;
                  remaining <= remaining - 8'd1;
`ifdef CHECKSUM_EN
                  csum      <= csum + mem_wdata;
`endif
                  if (remaining == 8'd1) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= FIN;
                  end else begin
                     mem_addr <= src_ptr + ONE_A;
                     mem_read <= in_range(src_ptr + ONE_A);
                     state    <= RD;
                  end
               end
            end

            FIN: begin
               // start is deliberately not looked at here.
               done  <= 1'b0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
